// File: rtl/fetch_unit.sv
// fetch_unit: fetch-stage PC generator with a registered instruction latch and valid/ready output.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc,
  input  logic [39:0]       instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [39:0]       out_instr,
  output logic [2:0]        out_len,
  output logic [31:0]       out_pc,
  output logic              out_illegal,
  output logic              halted,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_stalls
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0;
  logic [2:0]  len_p0;
  logic        ill_p0;
  logic        vld_p1;
  logic [39:0] instr_p1;
  logic [2:0]  len_p1;
  logic [31:0] pc_p1;
  logic        ill_p1;
  logic        capture;
  logic        accept;

  // Returns {illegal, length}; unknown opcodes fall back to a single byte.
  function automatic logic [3:0] decode_len(input logic [7:0] op);
    if (op inside {8'h05, 8'h2D, 8'hE9, [8'hB8:8'hBF]})
      return {1'b0, 3'd5};
    else if (op inside {8'h01, 8'h29, 8'h89, 8'h8B, 8'h31, 8'hEB, 8'h74, 8'h75})
      return {1'b0, 3'd2};
    else if (op inside {8'h90, 8'hF4, [8'h40:8'h4F]})
      return {1'b0, 3'd1};
    else
      return {1'b1, 3'd1};
  endfunction

  always_comb begin
    {ill_p0, len_p0} = decode_len(instr[7:0]);
  end

  assign capture = (state_q == RUN) && (!vld_p1 || out_ready) && !redirect_valid;
  assign accept  = vld_p1 && out_ready;

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = RUN;
    else if (capture && (instr[7:0] == 8'hF4))
      state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Stage p0 (PC / memory window) -> p1 (output register)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      len_p1   <= '0;
      pc_p1    <= '0;
      ill_p1   <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0  <= redirect_pc;
      vld_p1 <= 1'b0;
    end else if (capture) begin
      pc_p0    <= pc_p0 + {29'd0, len_p0};
      vld_p1   <= 1'b1;
      instr_p1 <= instr;
      len_p1   <= len_p0;
      pc_p1    <= pc_p0;
      ill_p1   <= ill_p0;
    end else if (accept) begin
      vld_p1 <= 1'b0;
    end
  end

  assign pc          = pc_p0;
  assign out_valid   = vld_p1;
  assign out_instr   = instr_p1;
  assign out_len     = len_p1;
  assign out_pc      = pc_p1;
  assign out_illegal = ill_p1;
  assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] fetched_q;
  logic [PERF_W-1:0] stalls_q;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (accept)
        fetched_q <= sat_inc(fetched_q);
      if (vld_p1 && !out_ready)
        stalls_q <= sat_inc(stalls_q);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule
